// File: rtl/scene_switch_ctl.sv
// Scene selector for the VGA path: menu hit-test, debounced back button, frame-aligned switching.
// Optional macro SCENE_BLANK_FRAME_EN blanks rgb for one frame after each switch.
module scene_switch_ctl #(
  parameter int N_SCENES   = 4,
  parameter int RGB_W      = 12,
  parameter int POS_W      = 12,
  parameter int MENU_X0    = 362,
  parameter int MENU_X1    = 674,
  parameter int ITEM_Y0    = 46,
  parameter int ITEM_H     = 101,
  parameter int ITEM_PITCH = 288,
  parameter int DEB_CYC    = 16,
  localparam int SID_W     = $clog2(N_SCENES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vsync_tim,
  input  logic [N_SCENES-1:0]       hsync_sc,
  input  logic [N_SCENES-1:0]       vsync_sc,
  input  logic [N_SCENES*RGB_W-1:0] rgb_sc,
  input  logic [POS_W-1:0]          xpos,
  input  logic [POS_W-1:0]          ypos,
  input  logic                      mouse_left,
  input  logic                      button,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [RGB_W-1:0]          rgb_out,
  output logic [SID_W-1:0]          scene_id,
  output logic                      switch_pulse
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  typedef enum logic {
    SHOW,
    PEND
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [SID_W-1:0] tgt;
  logic [SID_W-1:0] tgt_d;
  logic [SID_W-1:0] sid_d;
  logic             pulse_d;

  logic             mouse_q;
  logic             vs_q;
  logic             click_rise;
  logic             vs_rise;

  logic [1:0]       btn_sync;
  logic             btn_acc;
  logic             btn_acc_q;
  logic [CNT_W-1:0] deb_cnt;
  logic             back_ev;

  logic             x_in;
  logic             hit;
  logic [SID_W-1:0] hit_idx;

  logic             sel_h;
  logic             sel_v;
  logic [RGB_W-1:0] sel_rgb;

  function automatic logic [POS_W-1:0] item_lo(int k);
    return POS_W'(ITEM_Y0 + (k - 1) * ITEM_PITCH);
  endfunction

  function automatic logic [POS_W-1:0] item_hi(int k);
    return POS_W'(ITEM_Y0 + (k - 1) * ITEM_PITCH + ITEM_H - 1);
  endfunction

  assign click_rise = mouse_left & ~mouse_q;
  assign vs_rise    = vsync_tim & ~vs_q;
  assign back_ev    = btn_acc & ~btn_acc_q;

  // Previous-value registers for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_q <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      mouse_q <= mouse_left;
      vs_q    <= vsync_tim;
    end
  end

  // Button sync and debounce: accept a level after DEB_CYC steady cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync  <= 2'b00;
      btn_acc   <= 1'b0;
      btn_acc_q <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      btn_sync  <= {btn_sync[0], button};
      btn_acc_q <= btn_acc;
      if (btn_sync[1] == btn_acc) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_W'(DEB_CYC - 1)) begin
        btn_acc <= btn_sync[1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // Menu hit test: items share an x band and stack vertically.
  always_comb begin
    x_in    = (xpos >= POS_W'(MENU_X0)) &&
              (xpos <= POS_W'(MENU_X1));
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 1; k < N_SCENES; k++) begin
      if (x_in && ypos >= item_lo(k) &&
          ypos <= item_hi(k)) begin
        hit     = 1'b1;
        hit_idx = SID_W'(k);
      end
    end
  end

  // Request FSM state, target and displayed scene registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SHOW;
      tgt          <= '0;
      scene_id     <= '0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      tgt          <= tgt_d;
      scene_id     <= sid_d;
      switch_pulse <= pulse_d;
    end
  end

  // Next-state: latch the first request, commit it on the frame edge.
  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    sid_d   = scene_id;
    pulse_d = 1'b0;
    unique case (state)
      SHOW: begin
        if (click_rise && scene_id == '0 && hit &&
            hit_idx != scene_id) begin
          state_d = PEND;
          tgt_d   = hit_idx;
        end else if (back_ev && scene_id != '0) begin
          state_d = PEND;
          tgt_d   = '0;
        end
      end
      PEND: begin
        if (vs_rise) begin
          state_d = SHOW;
          sid_d   = tgt;
          pulse_d = 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  // Scene mux; anything unmatched falls back to the menu.
  always_comb begin
    sel_h   = hsync_sc[0];
    sel_v   = vsync_sc[0];
    sel_rgb = rgb_sc[RGB_W-1:0];
    for (int k = 1; k < N_SCENES; k++) begin
      if (scene_id == SID_W'(k)) begin
        sel_h   = hsync_sc[k];
        sel_v   = vsync_sc[k];
        sel_rgb = rgb_sc[k*RGB_W +: RGB_W];
      end
    end
  end

`ifdef SCENE_BLANK_FRAME_EN
  logic blank_q;

  // Blank flag covers the frame that starts at the switching edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 1'b0;
    end else if (pulse_d) begin
      blank_q <= 1'b1;
    end else if (vs_rise) begin
      blank_q <= 1'b0;
    end
  end

  // Registered outputs; colour suppressed while blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      hsync_out <= sel_h;
      vsync_out <= sel_v;
      rgb_out   <= blank_q ? '0 : sel_rgb;
    end
  end
`else
  // Registered outputs, one cycle behind the scene inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      hsync_out <= sel_h;
      vsync_out <= sel_v;
      rgb_out   <= sel_rgb;
    end
  end
`endif

endmodule
